conv3x3_stream: RTL and testbench

Second-generation streaming 3x3 convolution engine for the image-processing pipeline. It uses a full ready/valid handshake on input and output, and frame framing via start-of-frame and end-of-line markers. It takes runtime-loadable signed kernel coefficients, applies a runtime arithmetic shift, and saturates the result to an unsigned pixel range. Only "valid" (interior) convolution outputs are emitted: an (IMAGE_WIDTH-2) x (IMAGE_HEIGHT-2) image per input frame.

---
 rtl/conv_pkg.sv | 31 +++
 rtl/line_buffer.sv | 24 ++
 rtl/conv3x3_stream.sv | 190 +++++++++++++++++++
 tb/tb_conv3x3_stream.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared constants and types for the streaming 3x3 convolution engine.
package conv_pkg;

    localparam int unsigned K_NUM           = 9;
    localparam int unsigned DEF_COEFF_WIDTH = 8;

    // Kernel / window indices, row-major, top row first.
    localparam int unsigned K_TL = 0;
    localparam int unsigned K_TC = 1;
    localparam int unsigned K_TR = 2;
    localparam int unsigned K_ML = 3;
    localparam int unsigned K_CC = 4;
    localparam int unsigned K_MR = 5;
    localparam int unsigned K_BL = 6;
    localparam int unsigned K_BC = 7;
    localparam int unsigned K_BR = 8;

    typedef logic signed [DEF_COEFF_WIDTH-1:0] kernel_t [0:K_NUM-1];

    localparam kernel_t IDENTITY_KERNEL = '{
        DEF_COEFF_WIDTH'(0), DEF_COEFF_WIDTH'(0), DEF_COEFF_WIDTH'(0),
        DEF_COEFF_WIDTH'(0), DEF_COEFF_WIDTH'(1), DEF_COEFF_WIDTH'(0),
        DEF_COEFF_WIDTH'(0), DEF_COEFF_WIDTH'(0), DEF_COEFF_WIDTH'(0)
    };

    // Accumulator width: one sign bit plus four bits of growth for nine terms.
    function automatic int unsigned acc_width(input int unsigned pw, input int unsigned cw);
        return pw + cw + 5;
    endfunction

endpackage

// File: rtl/line_buffer.sv
// Circular single-line delay; combinational read returns the old entry at the write address.
module line_buffer #(
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WIDTH-1:0]      wdata,
    output logic [WIDTH-1:0]      rdata_c
);

    logic [WIDTH-1:0] mem [DEPTH];

    assign rdata_c = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 convolution with ready/valid, runtime kernel/shift and unsigned saturation.
// Define CONV3X3_STREAM_ABS_EN to emit the magnitude of negative results instead of 0.
module conv3x3_stream
    import conv_pkg::*;
#(
    parameter int unsigned PIXEL_WIDTH  = 8,
    parameter int unsigned IMAGE_WIDTH  = 64,
    parameter int unsigned IMAGE_HEIGHT = 64,
    parameter int unsigned COEFF_WIDTH  = DEF_COEFF_WIDTH,
    parameter int unsigned SHIFT_WIDTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [PIXEL_WIDTH-1:0]        s_data,
    input  logic                          s_sof,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [PIXEL_WIDTH-1:0]        m_data,
    output logic                          m_sof,
    output logic                          m_eol,
    input  logic                          coeff_we,
    input  logic [3:0]                    coeff_addr,
    input  logic signed [COEFF_WIDTH-1:0] coeff_wdata,
    input  logic [SHIFT_WIDTH-1:0]        shift,
    output logic                          frame_done
);

    localparam int unsigned ACC_W  = acc_width(PIXEL_WIDTH, COEFF_WIDTH);
    localparam int unsigned PROD_W = PIXEL_WIDTH + 1 + COEFF_WIDTH;
    localparam int unsigned COL_W  = $clog2(IMAGE_WIDTH);
    localparam int unsigned ROW_W  = $clog2(IMAGE_HEIGHT);
    localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'((1 << PIXEL_WIDTH) - 1);

    logic en, accept;
    logic [COL_W-1:0] col_q, cur_col;
    logic [ROW_W-1:0] row_q, cur_row;
    logic last_col, last_row, at_origin, qualify;

    logic signed [COEFF_WIDTH-1:0] shadow_k [K_NUM];
    logic signed [COEFF_WIDTH-1:0] act_k    [K_NUM];
    logic [SHIFT_WIDTH-1:0]        shift_act;

    logic [PIXEL_WIDTH-1:0] lb0_rd, lb1_rd;
    logic [PIXEL_WIDTH-1:0] win      [K_NUM];
    logic [PIXEL_WIDTH-1:0] win_next [K_NUM];

    logic signed [PROD_W-1:0] prod_c  [K_NUM];
    logic signed [PROD_W-1:0] s1_prod [K_NUM];
    logic                     s1_valid, s1_sof, s1_eol;
    logic [SHIFT_WIDTH-1:0]   s1_shift;

    logic signed [ACC_W-1:0] acc_c, sh_c, mag_c;
    logic [PIXEL_WIDTH-1:0]  sat_c;

    assign en      = !m_valid || m_ready;
    assign s_ready = en;
    assign accept  = s_valid && en;

    // An accepted s_sof pixel is (0,0) whatever the counters say.
    always_comb begin
        cur_col   = s_sof ? '0 : col_q;
        cur_row   = s_sof ? '0 : row_q;
        last_col  = (cur_col == COL_W'(IMAGE_WIDTH - 1));
        last_row  = (cur_row == ROW_W'(IMAGE_HEIGHT - 1));
        at_origin = (cur_col == '0) && (cur_row == '0);
        qualify   = (cur_row >= ROW_W'(2)) && (cur_col >= COL_W'(2));
    end

    line_buffer #(
        .DEPTH      (IMAGE_WIDTH),
        .WIDTH      (PIXEL_WIDTH),
        .ADDR_WIDTH (COL_W)
    ) u_lb0 (
        .clk     (clk),
        .we      (accept),
        .addr    (cur_col),
        .wdata   (s_data),
        .rdata_c (lb0_rd)
    );

    line_buffer #(
        .DEPTH      (IMAGE_WIDTH),
        .WIDTH      (PIXEL_WIDTH),
        .ADDR_WIDTH (COL_W)
    ) u_lb1 (
        .clk     (clk),
        .we      (accept),
        .addr    (cur_col),
        .wdata   (lb0_rd),
        .rdata_c (lb1_rd)
    );

    // Window shifts left; products are formed from the post-shift window so latency stays at two.
    always_comb begin
        win_next[K_TL] = win[K_TC];
        win_next[K_TC] = win[K_TR];
        win_next[K_TR] = lb1_rd;
        win_next[K_ML] = win[K_CC];
        win_next[K_CC] = win[K_MR];
        win_next[K_MR] = lb0_rd;
        win_next[K_BL] = win[K_BC];
        win_next[K_BC] = win[K_BR];
        win_next[K_BR] = s_data;
        for (int unsigned i = 0; i < K_NUM; i++) begin
            prod_c[i] = PROD_W'($signed({1'b0, win_next[i]})) * PROD_W'(act_k[i]);
        end
    end

    always_comb begin
        acc_c = '0;
        for (int unsigned i = 0; i < K_NUM; i++) begin
            acc_c = acc_c + ACC_W'(s1_prod[i]);
        end
        sh_c = acc_c >>> s1_shift;
`ifdef CONV3X3_STREAM_ABS_EN
        mag_c = sh_c[ACC_W-1] ? -sh_c : sh_c;
`else
        mag_c = sh_c[ACC_W-1] ? '0 : sh_c;
`endif
        sat_c = (mag_c > PIX_MAX) ? PIX_MAX[PIXEL_WIDTH-1:0] : mag_c[PIXEL_WIDTH-1:0];
    end

    // Datapath storage needs no reset; stale contents are never qualified.
    always_ff @(posedge clk) begin
        if (accept) begin
            win <= win_next;
        end
        if (en) begin
            s1_prod <= prod_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q      <= '0;
            row_q      <= '0;
            frame_done <= 1'b0;
            shift_act  <= '0;
            s1_valid   <= 1'b0;
            s1_sof     <= 1'b0;
            s1_eol     <= 1'b0;
            s1_shift   <= '0;
            m_valid    <= 1'b0;
            m_data     <= '0;
            m_sof      <= 1'b0;
            m_eol      <= 1'b0;
            for (int unsigned i = 0; i < K_NUM; i++) begin
                shadow_k[i] <= COEFF_WIDTH'(IDENTITY_KERNEL[i]);
                act_k[i]    <= COEFF_WIDTH'(IDENTITY_KERNEL[i]);
            end
        end else begin
            frame_done <= accept && last_col && last_row;

            if (coeff_we && (coeff_addr < 4'(K_NUM))) begin
                shadow_k[coeff_addr] <= coeff_wdata;
            end

            if (accept) begin
                col_q <= last_col ? '0 : cur_col + COL_W'(1);
                if (last_col) begin
                    row_q <= last_row ? '0 : cur_row + ROW_W'(1);
                end else begin
                    row_q <= cur_row;
                end
                // Commit folds in a same-cycle coefficient write.
                if (at_origin) begin
                    shift_act <= shift;
                    for (int unsigned i = 0; i < K_NUM; i++) begin
                        act_k[i] <= (coeff_we && (coeff_addr == 4'(i))) ? coeff_wdata
                                                                         : shadow_k[i];
                    end
                end
            end

            if (en) begin
                s1_valid <= accept && qualify;
                s1_sof   <= (cur_row == ROW_W'(2)) && (cur_col == COL_W'(2));
                s1_eol   <= last_col;
                s1_shift <= shift_act;
                m_valid  <= s1_valid;
                m_data   <= sat_c;
                m_sof    <= s1_sof;
                m_eol    <= s1_eol;
            end
        end
    end

endmodule

// File: tb/tb_conv3x3_stream.sv
// Scoreboard bench for conv3x3_stream on a 5x4 frame (3x2 output per frame).
module tb_conv3x3_stream;

    localparam int unsigned PW = 8;
    localparam int unsigned IW = 5;
    localparam int unsigned IH = 4;
    localparam int unsigned CW = 8;
    localparam int unsigned SW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          s_valid, s_ready, s_sof;
    logic [PW-1:0] s_data;
    logic          m_valid, m_ready, m_sof, m_eol;
    logic [PW-1:0] m_data;
    logic          coeff_we;
    logic [3:0]    coeff_addr;
    logic [CW-1:0] coeff_wdata;
    logic [SW-1:0] shift;
    logic          frame_done;

    conv3x3_stream #(
        .PIXEL_WIDTH  (PW),
        .IMAGE_WIDTH  (IW),
        .IMAGE_HEIGHT (IH),
        .COEFF_WIDTH  (CW),
        .SHIFT_WIDTH  (SW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_sof       (s_sof),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_sof       (m_sof),
        .m_eol       (m_eol),
        .coeff_we    (coeff_we),
        .coeff_addr  (coeff_addr),
        .coeff_wdata (coeff_wdata),
        .shift       (shift),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [PW-1:0] data;
        logic          sof;
        logic          eol;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   mon_en = 1'b0;
    bit   hold_vld = 1'b0;
    int   hold_val = 0;

    int ramp_id[6] = '{11, 12, 13, 21, 22, 23};
    int ramp_box[6] = '{99, 108, 117, 189, 198, 207};
    int k_id[9]  = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
    int k_box[9] = '{1, 1, 1, 1, 1, 1, 1, 1, 1};

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_frame(input int v[6]);
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            e.data = PW'(v[i]);
            e.sof  = (i == 0);
            e.eol  = (i == 2) || (i == 5);
            exp_q.push_back(e);
        end
    endtask

    task automatic push_const(input int v);
        int a[6];
        for (int i = 0; i < 6; i++) a[i] = v;
        push_frame(a);
    endtask

    task automatic send(input int px, input bit sof, input bit last);
        int t;
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = PW'(px);
        s_sof   = sof;
        t = 0;
        while (!s_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!s_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL s_ready_timeout: got 0, expected 1 at %0t", $time);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_sof   = 1'b0;
        check(last ? "frame_done_last" : "frame_done_idle", int'(frame_done), last ? 1 : 0);
    endtask

    // Sends raster indices first..final; ramp pixel is 10*row+col, else constant cval.
    task automatic send_range(input bit ramp, input int cval, input int first,
                              input int final_idx, input bit sof_first);
        for (int i = first; i <= final_idx; i++) begin
            send(ramp ? (10 * (i / IW) + (i % IW)) : cval,
                 sof_first && (i == first), i == IW * IH - 1);
        end
    endtask

    task automatic write_coeff(input int addr, input int val);
        @(negedge clk);
        coeff_we    = 1'b1;
        coeff_addr  = 4'(addr);
        coeff_wdata = CW'(val);
        @(posedge clk);
        #1;
        coeff_we = 1'b0;
    endtask

    task automatic set_kernel(input int k[9]);
        for (int i = 0; i < 9; i++) write_coeff(i, k[i]);
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check(name, exp_q.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    // Monitor: pops on every handshake and checks hold-stability during backpressure.
    always @(negedge clk) begin
        if (mon_en) begin
            if (m_valid && !m_ready) begin
                check("s_ready_stall", int'(s_ready), 0);
                if (hold_vld) check("hold_stable", int'({m_data, m_sof, m_eol}), hold_val);
                hold_vld = 1'b1;
                hold_val = int'({m_data, m_sof, m_eol});
            end else begin
                hold_vld = 1'b0;
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_out: got data=%0d sof=%0b eol=%0b, expected none",
                             m_data, m_sof, m_eol);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("out{data,sof,eol}", int'({m_data, m_sof, m_eol}), int'(e));
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int neg_exp;
        rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_sof = 1'b0; m_ready = 1'b1;
        coeff_we = 1'b0; coeff_addr = '0; coeff_wdata = '0; shift = '0;
        repeat (3) @(negedge clk);
        check("rst_m_valid", int'(m_valid), 0);
        check("rst_s_ready", int'(s_ready), 1);
        check("rst_m_data", int'(m_data), 0);
        check("rst_m_sof", int'(m_sof), 0);
        check("rst_m_eol", int'(m_eol), 0);
        check("rst_frame_done", int'(frame_done), 0);
        rst_n = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);

        // Reset kernel is identity: ramp passes the centre through.
        push_frame(ramp_id);
        send_range(1'b1, 0, 0, 19, 1'b1);
        drain("drain_identity");

        // Box kernel, shift 3, constant 80: 720 >> 3 = 90.
        set_kernel(k_box);
        shift = SW'(3);
        push_const(90);
        send_range(1'b0, 80, 0, 19, 1'b1);
        drain("drain_box_shift");

        // Centre 8 on 255 saturates high.
        shift = '0;
        set_kernel('{0, 0, 0, 0, 8, 0, 0, 0, 0});
        push_const(255);
        send_range(1'b0, 255, 0, 19, 1'b1);
        drain("drain_sat_high");

        // Centre -1 on 255: clamp to 0, or magnitude when the abs option is built in.
`ifdef CONV3X3_STREAM_ABS_EN
        neg_exp = 255;
`else
        neg_exp = 0;
`endif
        write_coeff(4, -1);
        push_const(neg_exp);
        send_range(1'b0, 255, 0, 19, 1'b1);
        drain("drain_negative");

        // Backpressure: m_ready low for 5 cycles while outputs are flowing.
        set_kernel(k_id);
        push_frame(ramp_id);
        fork
            send_range(1'b1, 0, 0, 19, 1'b1);
            begin
                repeat (15) @(posedge clk);
                #2 m_ready = 1'b0;
                repeat (5) @(posedge clk);
                #2 m_ready = 1'b1;
            end
        join
        drain("drain_stall");

        // Box written mid-frame A applies only from frame B, which starts by wrap (no s_sof).
        push_frame(ramp_id);
        push_frame(ramp_box);
        send_range(1'b1, 0, 0, 7, 1'b1);
        set_kernel(k_box);
        write_coeff(12, 5);
        send_range(1'b1, 0, 8, 19, 1'b0);
        send_range(1'b1, 0, 0, 19, 1'b0);
        drain("drain_kernel_switch");

        // Abort after six pixels with a fresh s_sof on input 7.
        set_kernel(k_id);
        push_frame(ramp_id);
        send_range(1'b1, 0, 0, 5, 1'b1);
        send_range(1'b1, 0, 0, 19, 1'b1);
        drain("drain_sof_abort");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
